// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU pipeline-control types.
//   state_e          : controller FSM states
//   ctrl_t           : per-cycle pipeline register enables and flushes
//   MEM_TIMEOUT_DEF  : default bound on cycles spent waiting for memory
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    ECALL_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] MEM_TIMEOUT_DEF = 8'd255;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Canned control words.
  localparam ctrl_t CTRL_GO     = 7'b11111_00; // everything advances
  localparam ctrl_t CTRL_HOLD   = 7'b00000_00; // whole pipe frozen
  localparam ctrl_t CTRL_BRANCH = 7'b11111_11; // redirect: kill IF and ID
  localparam ctrl_t CTRL_BUBBLE = 7'b00111_01; // load-use: hold front, bubble EX

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, async active-low clear
//   inc_i      : add one on this edge (sticks at all-ones)
//   count_o    : current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     count_q <= '0;
    else if (inc_i && !(&count_q))  count_q <= count_q + WIDTH'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for a 5-stage CPU.
//   clk, rst                    : clock, async active-low reset
//   hazard_stall, branch_taken  : load-use stall / EX redirect
//   ecall_ex, ecall_done        : ECALL in EX / its service finished
//   mem_req, mem_ready          : MEM stage needs the port / data valid
//   pc_en .. mem_wb_en          : per-register write enables
//   if_id_flush, id_ex_flush    : bubble insertion
//   mem_err                     : sticky memory-timeout flag
//   stall_cycles                : saturating count of cycles with any enable low
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int         PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_stall,
  input  logic              branch_taken,
  input  logic              ecall_ex,
  input  logic              ecall_done,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cycles
);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       mem_err_q, mem_err_d;
  ctrl_t      ctrl;
  logic       stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    ctrl      = CTRL_GO;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          ctrl    = CTRL_HOLD;
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end else if (ecall_ex) begin
          ctrl    = CTRL_HOLD;
          state_d = ECALL_WAIT;
        end else if (branch_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (hazard_stall) begin
          ctrl = CTRL_BUBBLE;
        end
      end
      MEM_WAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        // Data arrival or timeout both release the pipe for one cycle.
        if (mem_ready) begin
          state_d = RUN;
        end else if (wcnt_q == MEM_TIMEOUT - 8'd1) begin
          mem_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          ctrl = CTRL_HOLD;
        end
      end
      ECALL_WAIT: begin
        // Release cycle goes straight to RUN; ecall_ex is not looked at here.
        if (ecall_done) state_d = RUN;
        else            ctrl    = CTRL_HOLD;
      end
      default: state_d = RUN;
    endcase
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign mem_err     = mem_err_q;

  assign stall = ~&{ctrl.pc_en, ctrl.if_id_en, ctrl.id_ex_en,
                    ctrl.ex_mem_en, ctrl.mem_wb_en};

  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (stall),
    .count_o (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int         TMO = 4;
  localparam int         PW  = 8;
  localparam int         SAT = (1 << PW) - 1;

  localparam logic [6:0] E_ON  = 7'b11111_00;
  localparam logic [6:0] E_FRZ = 7'b00000_00;
  localparam logic [6:0] E_BR  = 7'b11111_11;
  localparam logic [6:0] E_HZ  = 7'b00111_01;

  logic clk, rst;
  logic hazard_stall, branch_taken, ecall_ex, ecall_done, mem_req, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_err;
  logic [PW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(8'd4), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .ecall_ex(ecall_ex), .ecall_done(ecall_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model. The pipeline is either running, waiting on memory
  // (with a tally of frozen cycles that this access has cost so far), or
  // waiting on an ECALL service. Checked on every falling edge.
  int m_wait;   // 0 none, 1 memory, 2 ecall
  int m_frozen;
  bit m_err;
  int m_cnt;

  always @(negedge clk) begin
    logic [6:0] e;
    if (!rst) begin
      m_wait = 0; m_frozen = 0; m_err = 0; m_cnt = 0;
    end
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    e = E_ON;
    if (m_wait == 0) begin
      if (mem_req && !mem_ready) e = E_FRZ;
      else if (ecall_ex)         e = E_FRZ;
      else if (branch_taken)     e = E_BR;
      else if (hazard_stall)     e = E_HZ;
    end else if (m_wait == 1) begin
      // Release on data, or once the access has already cost TMO frozen cycles.
      if (!mem_ready && m_frozen < TMO) e = E_FRZ;
    end else begin
      if (!ecall_done) e = E_FRZ;
    end
    chk("ctrl_word", 32'(outs()), 32'(e));

    if (rst) begin
      if (e[6:2] != 5'b11111 && m_cnt < SAT) m_cnt++;
      if (m_wait == 0) begin
        if (mem_req && !mem_ready) begin m_wait = 1; m_frozen = 1; end
        else if (ecall_ex)         m_wait = 2;
      end else if (m_wait == 1) begin
        if (mem_ready) m_wait = 0;
        else if (m_frozen >= TMO) begin m_wait = 0; m_err = 1; end
        else m_frozen++;
      end else if (ecall_done) begin
        m_wait = 0;
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge; return at the
  // falling edge so the caller can inspect that cycle's outputs.
  task automatic cyc(input logic r, input logic hz, input logic br, input logic ec,
                     input logic ed, input logic mr, input logic my);
    @(posedge clk); #1;
    rst = r; hazard_stall = hz; branch_taken = br; ecall_ex = ec;
    ecall_done = ed; mem_req = mr; mem_ready = my;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; hazard_stall = 0; branch_taken = 0; ecall_ex = 0;
    ecall_done = 0; mem_req = 0; mem_ready = 0;

    // reset state
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0);
    chk("lit_rst_stall", 32'(stall_cycles), 0);
    chk("lit_rst_err", 32'(mem_err), 0);
    chk("lit_rst_outs", 32'(outs()), 32'h7c);

    // load-use stall
    cyc(1,0,0,0,0,0,0);
    cyc(1,1,0,0,0,0,0);
    chk("lit_hz_outs", 32'(outs()), 32'h1d);
    cyc(1,0,0,0,0,0,0);
    chk("lit_hz_stall", 32'(stall_cycles), 1);

    // branch beats hazard
    cyc(1,1,1,0,0,0,0);
    chk("lit_br_outs", 32'(outs()), 32'h7f);
    cyc(1,0,0,0,0,0,0);
    chk("lit_br_stall", 32'(stall_cycles), 1);

    // memory wait: 3 frozen, 1 release
    repeat (3) cyc(1,0,0,0,0,1,0);
    cyc(1,0,0,0,0,1,1);
    chk("lit_mem_release", 32'(outs()), 32'h7c);
    cyc(1,0,0,0,0,0,0);
    chk("lit_mem_stall", 32'(stall_cycles), 4);

    // memory timeout: 4 frozen then forced release
    repeat (4) cyc(1,0,0,0,0,1,0);
    chk("lit_tmo_frozen", 32'(outs()), 0);
    cyc(1,0,0,0,0,1,0);
    chk("lit_tmo_release", 32'(outs()), 32'h7c);
    cyc(1,0,0,0,0,0,0);
    chk("lit_tmo_err", 32'(mem_err), 1);
    chk("lit_tmo_stall", 32'(stall_cycles), 8);

    // memory wait outranks ecall, then the ecall is serviced
    cyc(1,0,0,1,0,1,0);
    cyc(1,0,0,1,0,1,1);
    chk("lit_ec_memrel", 32'(outs()), 32'h7c);
    cyc(1,0,0,1,0,0,0);
    chk("lit_ec_enter", 32'(outs()), 0);
    repeat (2) cyc(1,0,0,0,0,0,0);
    cyc(1,0,0,1,1,0,0);
    chk("lit_ec_release", 32'(outs()), 32'h7c);
    cyc(1,0,0,0,0,0,0);
    chk("lit_ec_run", 32'(outs()), 32'h7c);
    chk("lit_ec_stall", 32'(stall_cycles), 12);
    chk("lit_err_sticky", 32'(mem_err), 1);

    // reset abandons an ecall wait
    cyc(1,0,0,1,0,0,0);
    cyc(0,0,0,0,0,0,0);
    chk("lit_rst2_outs", 32'(outs()), 32'h7c);
    chk("lit_rst2_err", 32'(mem_err), 0);
    chk("lit_rst2_stall", 32'(stall_cycles), 0);
    cyc(1,0,0,0,0,0,0);
    chk("lit_rst2_run", 32'(outs()), 32'h7c);

    // randomized traffic; long runs saturate the 8-bit counter
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 249) != 0,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 30);
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd255; max cycles spent in MEM_WAIT before forced release.
REQ-002 SHALL have parameter PERF_W, default 32; width of the stall-cycle counter.
REQ-003 SHALL have ports clk input 1, the single clock; all state updates on posedge.
REQ-004 SHALL have ports rst input 1, asynchronous active-low reset.
REQ-005 SHALL have ports hazard_stall input 1, load-use stall request from the hazard detector.
REQ-006 SHALL have ports branch_taken input 1, EX-stage branch/jump redirect.
REQ-007 SHALL have ports ecall_ex input 1, ECALL instruction present in EX.
REQ-008 SHALL have ports ecall_done input 1, ECALL/IO service complete.
REQ-009 SHALL have ports mem_req input 1, the MEM-stage load/store needs the memory/MMIO port.
REQ-010 SHALL have ports mem_ready input 1, memory/MMIO data valid this cycle.
REQ-011 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en output 1 each, per-register write enables.
REQ-012 SHALL have ports if_id_flush, id_ex_flush output 1 each, load a bubble (NOP) into that register.
REQ-013 SHALL have ports mem_err output 1, sticky memory-timeout flag.
REQ-014 SHALL have ports stall_cycles output PERF_W, count of cycles with any enable low.

Function
REQ-015 SHALL implement FSM states RUN, MEM_WAIT, ECALL_WAIT; the enable/flush outputs SHALL be combinational from the current state and the current inputs.
REQ-016 In RUN, priority SHALL be: memory wait > ecall > branch > hazard stall > normal.
REQ-017 In RUN with mem_req=1 and mem_ready=0, all enables SHALL be 0 and the next state SHALL be MEM_WAIT; mem_req=1 with mem_ready=1 SHALL cause no wait.
REQ-018 In RUN with ecall_ex=1 (and no memory wait), all enables SHALL be 0 and the next state SHALL be ECALL_WAIT.
REQ-019 In RUN with branch_taken=1 (higher requests absent), all enables SHALL be 1 and if_id_flush=id_ex_flush=1 for that cycle; branch_taken SHALL override a coincident hazard_stall.
REQ-020 In RUN with hazard_stall=1 only, pc_en=if_id_en=0, id_ex_flush=1, id_ex_en=ex_mem_en=mem_wb_en=1.
REQ-021 In RUN with no request, all enables SHALL be 1 and all flushes 0.
REQ-022 In MEM_WAIT, all enables SHALL be 0 while mem_ready=0; mem_ready=1 SHALL give one release cycle with all enables 1, followed by RUN.
REQ-023 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle; when it equals MEM_TIMEOUT-1 with mem_ready=0, mem_err SHALL be set, a release cycle SHALL occur, and the next state SHALL be RUN.
REQ-024 In ECALL_WAIT, all enables SHALL be 0 until ecall_done=1; that cycle SHALL be a release cycle (all enables 1) and the next state SHALL be RUN; ecall_ex during the release cycle SHALL NOT re-trigger.
REQ-025 Inputs other than mem_ready/ecall_done SHALL be ignored in the wait states.
REQ-026 Flushes SHALL be 0 in every cycle outside REQ-019/REQ-020.
REQ-027 stall_cycles SHALL increment by 1 on each posedge where any enable is 0, saturating at all-ones.
REQ-028 mem_err SHALL remain 1 until reset.

Reset
REQ-029 rst=0 SHALL asynchronously force state RUN, wait counter 0, mem_err 0, stall_cycles 0; outputs SHALL then follow RUN rules.
REQ-030 Reset asserted during MEM_WAIT or ECALL_WAIT SHALL abandon the wait without asserting mem_err.

Structure
REQ-031 The state enum (RUN, MEM_WAIT, ECALL_WAIT) and the MEM_TIMEOUT default SHALL reside in the shared CPU package.
REQ-032 A sub-module sat_counter (parameter width, inc, async clear) SHALL implement stall_cycles; the FSM SHALL be inline.

Verification
REQ-033 Release rst, hazard_stall=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_cycles=1.
REQ-034 branch_taken=1 with hazard_stall=1 -> all enables 1, both flushes 1, stall_cycles unchanged.
REQ-035 mem_req=1, mem_ready low 3 cycles then high -> 3 frozen cycles plus 1 release cycle, state RUN, stall_cycles=3.
REQ-036 MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> release after 4 cycles, mem_err=1 held until rst.
REQ-037 ecall_ex=1 with mem_req=1, mem_ready=0 -> MEM_WAIT first; after mem_ready, ECALL_WAIT; ecall_done -> RUN.
REQ-038 rst pulsed low in ECALL_WAIT -> state RUN, all enables 1, mem_err=0, stall_cycles=0.
